// File: rtl/apb_slave_regfile.sv
// APB3 completer exposing NUM_REGS word registers with configurable wait states.
// Define APB_SLV_PROTOCOL_CHECK_EN to build the sticky protocol-violation checker.
module apb_slave_regfile #(
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] RESET_VAL   = 32'h0
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic        psel,
  input  logic        penable,
  input  logic [31:0] paddr,
  input  logic        pwrite,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic [31:0] ctrl_out,
  output logic        prot_err
);

  localparam int unsigned IW = $clog2(NUM_REGS);

  typedef enum logic {S_IDLE, S_ACCESS} state_e;

  state_e          state_q;
  logic [3:0]      cnt_q;
  logic [IW-1:0]   idx_q;
  logic            pwrite_q;
  logic            err_q;
  logic [31:0]     regs_q [NUM_REGS];

  logic [IW-1:0]   idx_d;
  logic            addr_err_d;
  logic            setup_ev;
  logic            complete_ev;
  logic            wr_en;
  logic [NUM_REGS-1:0] wr_sel;

  assign idx_d       = paddr[2 +: IW];
  assign addr_err_d  = (paddr[1:0] != 2'b00) || (paddr[31:2+IW] != '0);
  assign setup_ev    = (state_q == S_IDLE) && psel && !penable;
  assign complete_ev = (state_q == S_ACCESS) && psel && (cnt_q == 4'd0);
  assign wr_en       = complete_ev && pwrite_q && !err_q;

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      idx_q    <= '0;
      pwrite_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (setup_ev) begin
            state_q  <= S_ACCESS;
            cnt_q    <= 4'(WAIT_STATES);
            idx_q    <= idx_d;
            pwrite_q <= pwrite;
            err_q    <= addr_err_d;
          end
        end
        S_ACCESS: begin
          // A dropped psel abandons the transfer without a response.
          if (!psel || cnt_q == 4'd0) begin
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_wr_sel
      assign wr_sel[gi] = wr_en && (idx_q == IW'(gi));
    end
  endgenerate

  always_ff @(posedge pclk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (!presetn) begin
        regs_q[i] <= RESET_VAL;
      end else if (wr_sel[i]) begin
        regs_q[i] <= pwdata;
      end
    end
  end

  assign pready   = (state_q == S_ACCESS) && (cnt_q == 4'd0);
  assign pslverr  = pready && err_q;
  assign prdata   = (pready && !pwrite_q && !err_q) ? regs_q[idx_q] : 32'h0;
  assign ctrl_out = regs_q[0];

`ifdef APB_SLV_PROTOCOL_CHECK_EN
  logic [31:0] paddr_q;
  logic        prot_err_q;
  logic        viol;

  assign viol = ((state_q == S_IDLE) && psel && penable) ||
                ((state_q == S_ACCESS) && psel && ((paddr != paddr_q) || (pwrite != pwrite_q))) ||
                ((state_q == S_ACCESS) && !psel && !pready);

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      paddr_q    <= 32'h0;
      prot_err_q <= 1'b0;
    end else begin
      if (setup_ev) begin
        paddr_q <= paddr;
      end
      if (viol) begin
        prot_err_q <= 1'b1;
      end
    end
  end

  assign prot_err = prot_err_q;
`else
  assign prot_err = 1'b0;
`endif

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Self-checking bench: two instances (0 and 3 wait states) on a muxed APB bus,
// table vectors, a word-array reference model with random traffic, and corner sequences.
module tb_apb_slave_regfile;

  localparam int          NR   = 16;
  localparam int          WS_A = 0;
  localparam int          WS_B = 3;
  localparam logic [31:0] RV_A = 32'h0;
  localparam logic [31:0] RV_B = 32'h5A5A_0000;
`ifdef APB_SLV_PROTOCOL_CHECK_EN
  localparam logic PC = 1'b1;
`else
  localparam logic PC = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        presetn = 1'b0;
  logic        psel    = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite  = 1'b0;
  logic [31:0] paddr   = 32'h0;
  logic [31:0] pwdata  = 32'h0;
  int          sel     = 0;

  logic        psel_a, psel_b;
  logic [31:0] prdata_a, prdata_b, ctrl_a, ctrl_b;
  logic        pready_a, pready_b, pslverr_a, pslverr_b, prot_a, prot_b;
  logic [31:0] prdata_m, ctrl_m;
  logic        pready_m, pslverr_m, prot_m;

  assign psel_a    = psel && (sel == 0);
  assign psel_b    = psel && (sel == 1);
  assign prdata_m  = (sel == 1) ? prdata_b  : prdata_a;
  assign ctrl_m    = (sel == 1) ? ctrl_b    : ctrl_a;
  assign pready_m  = (sel == 1) ? pready_b  : pready_a;
  assign pslverr_m = (sel == 1) ? pslverr_b : pslverr_a;
  assign prot_m    = (sel == 1) ? prot_b    : prot_a;

  apb_slave_regfile #(.NUM_REGS(NR), .WAIT_STATES(WS_A), .RESET_VAL(RV_A)) dut_a (
    .pclk(clk), .presetn(presetn), .psel(psel_a), .penable(penable), .paddr(paddr),
    .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata_a), .pready(pready_a),
    .pslverr(pslverr_a), .ctrl_out(ctrl_a), .prot_err(prot_a)
  );

  apb_slave_regfile #(.NUM_REGS(NR), .WAIT_STATES(WS_B), .RESET_VAL(RV_B)) dut_b (
    .pclk(clk), .presetn(presetn), .psel(psel_b), .penable(penable), .paddr(paddr),
    .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata_b), .pready(pready_b),
    .pslverr(pslverr_b), .ctrl_out(ctrl_b), .prot_err(prot_b)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] mdl [2][NR];
  logic        exp_prot [2];

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs [12];

  function automatic logic [31:0] rv(input int d);
    return (d == 1) ? RV_B : RV_A;
  endfunction

  function automatic int ws(input int d);
    return (d == 1) ? WS_B : WS_A;
  endfunction

  // Reference decode: a legal address is word aligned and inside the register window.
  function automatic logic m_err(input logic [31:0] a);
    return (a % 4 != 0) || (a >= 32'(NR * 4));
  endfunction

  task automatic mdl_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < NR; i++) mdl[d][i] = rv(d);
      exp_prot[d] = 1'b0;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    presetn = 1'b0; psel = 1'b0; penable = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    chk("rst_pready",  {pready_a, pready_b}, 32'h0);
    chk("rst_prdata",  prdata_a | prdata_b, 32'h0);
    chk("rst_pslverr", {pslverr_a, pslverr_b}, 32'h0);
    chk("rst_prot",    {prot_a, prot_b}, 32'h0);
    @(negedge clk);
    presetn = 1'b1;
    mdl_reset();
    @(posedge clk);
    #1;
    chk("post_rst_out", {pready_a, pready_b, pslverr_a, pslverr_b, prot_a, prot_b}, 32'h0);
    chk("post_rst_prdata", prdata_a | prdata_b, 32'h0);
    chk("post_rst_ctrl_a", ctrl_a, RV_A);
    chk("post_rst_ctrl_b", ctrl_b, RV_B);
  endtask

  // One APB transfer; returns just after the completing edge with psel still high.
  task automatic xfer(input int d, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic err, output int cyc,
                      output logic [31:0] ctrl_pre);
    int waits;
    bit done;
    @(negedge clk);
    sel = d; psel = 1'b1; penable = 1'b0; paddr = a; pwrite = wr; pwdata = wd;
    @(posedge clk);
    @(negedge clk);
    penable = 1'b1;
    waits = 0; done = 0; rd = 32'h0; err = 1'b0; ctrl_pre = 32'h0;
    while (!done && waits < 40) begin
      if (pready_m) begin
        rd = prdata_m; err = pslverr_m; ctrl_pre = ctrl_m; done = 1;
      end else begin
        waits++;
        @(posedge clk);
        @(negedge clk);
      end
    end
    cyc = waits + 2;
    if (!done) begin
      chk("xfer_timeout", 32'd0, 32'd1);
      psel = 1'b0; penable = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic rtx(input int d, input logic wr, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] rd, ctrl_pre, e_rd, old0;
    logic        err, e_err;
    int          cyc, idx;
    e_err = m_err(a);
    idx   = e_err ? 0 : int'(a / 4);
    e_rd  = (!wr && !e_err) ? mdl[d][idx] : 32'h0;
    old0  = mdl[d][0];
    xfer(d, wr, a, wd, rd, err, cyc, ctrl_pre);
    if (wr && !e_err) mdl[d][idx] = wd;
    $display("xfer dut%0d %s addr=%h wdata=%h rdata=%h err=%0d cyc=%0d",
             d, wr ? "WR" : "RD", a, wd, rd, err, cyc);
    chk("rdata", rd, e_rd);
    chk("pslverr", {31'h0, err}, {31'h0, e_err});
    chk("cycles", cyc, 2 + ws(d));
    chk("ctrl_pre", ctrl_pre, old0);
    chk("ctrl_post", ctrl_m, mdl[d][0]);
    chk("prot_err", {31'h0, prot_m}, {31'h0, exp_prot[d]});
  endtask

  initial begin
    logic [31:0] rd, ctrl_pre, a, v;
    logic        err;
    int          cyc, k, r;
    bit          seen;

    vecs[0]  = '{1'b0, 32'h0000_0000, 32'h0,         32'h0,         1'b0};
    vecs[1]  = '{1'b0, 32'h0000_003C, 32'h0,         32'h0,         1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 32'h0,         1'b0};
    vecs[3]  = '{1'b0, 32'h0000_0008, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[4]  = '{1'b1, 32'h0000_0040, 32'h0000_FFFF, 32'h0,         1'b1};
    vecs[5]  = '{1'b0, 32'h0000_0000, 32'h0,         32'h0,         1'b0};
    vecs[6]  = '{1'b0, 32'h0000_0006, 32'h0,         32'h0,         1'b1};
    vecs[7]  = '{1'b0, 32'h0000_0000, 32'h0,         32'h0,         1'b0};
    vecs[8]  = '{1'b1, 32'h0000_003C, 32'h1234_5678, 32'h0,         1'b0};
    vecs[9]  = '{1'b0, 32'h0000_003C, 32'h0,         32'h1234_5678, 1'b0};
    vecs[10] = '{1'b1, 32'h0000_0005, 32'hFFFF_FFFF, 32'h0,         1'b1};
    vecs[11] = '{1'b0, 32'h8000_0004, 32'h0,         32'h0,         1'b1};

    mdl_reset();
    do_reset(2);

    for (int i = 0; i < 12; i++) begin
      v = mdl[0][0];
      xfer(0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, err, cyc, ctrl_pre);
      if (vecs[i].wr && !vecs[i].exp_err) mdl[0][vecs[i].addr[5:2]] = vecs[i].wdata;
      $display("vec %0d %s addr=%h rdata=%h err=%0d cyc=%0d",
               i, vecs[i].wr ? "WR" : "RD", vecs[i].addr, rd, err, cyc);
      chk("vec_rdata", rd, vecs[i].exp_rd);
      chk("vec_err", {31'h0, err}, {31'h0, vecs[i].exp_err});
      chk("vec_cycles", cyc, 2);
      chk("vec_ctrl_pre", ctrl_pre, v);
    end
    rtx(0, 1'b0, 32'h0000_0004, 32'h0);

    // Back-to-back write then read of the control word.
    rtx(0, 1'b1, 32'h0000_0000, 32'h0000_00A5);
    chk("b2b_ctrl", ctrl_a, 32'h0000_00A5);
    rtx(0, 1'b0, 32'h0000_0000, 32'h0);
    idle();

    // Wait-state instance: committed only on the pready edge.
    rtx(1, 1'b0, 32'h0000_0004, 32'h0);
    rtx(1, 1'b1, 32'h0000_0004, 32'h0000_1234);
    rtx(1, 1'b0, 32'h0000_0004, 32'h0);
    rtx(1, 1'b1, 32'h0000_0000, 32'h0000_1234);
    rtx(1, 1'b1, 32'h0000_0040, 32'h0000_FFFF);
    idle();

    for (int i = 0; i < 80; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7)       a = 32'($urandom_range(0, NR - 1)) * 4;
      else if (r == 7) a = 32'($urandom_range(0, NR - 1)) * 4 + 32'($urandom_range(1, 3));
      else if (r == 8) a = 32'(NR * 4) + 32'($urandom_range(0, 255)) * 4;
      else             a = $urandom;
      rtx(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom);
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();

    // Reset in the middle of a waiting write: the write must be abandoned.
    @(negedge clk);
    sel = 1; psel = 1'b1; penable = 1'b0; paddr = 32'h8; pwrite = 1'b1; pwdata = 32'hCAFE_F00D;
    @(posedge clk);
    @(negedge clk);
    penable = 1'b1;
    @(posedge clk);
    do_reset(1);
    rtx(1, 1'b0, 32'h0000_0008, 32'h0);
    idle();

    // psel dropped while waiting: no write, no response.
    @(negedge clk);
    sel = 1; psel = 1'b1; penable = 1'b0; paddr = 32'hC; pwrite = 1'b1; pwdata = 32'h0000_0077;
    @(posedge clk);
    @(negedge clk);
    penable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    exp_prot[1] = PC;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("drop_pready", {31'h0, pready_b}, 32'h0);
      chk("drop_prot", {31'h0, prot_b}, {31'h0, exp_prot[1]});
    end
    rtx(1, 1'b0, 32'h0000_000C, 32'h0);
    idle();

    // penable without a SETUP cycle.
    @(negedge clk);
    sel = 0; psel = 1'b1; penable = 1'b1; paddr = 32'h10; pwrite = 1'b0;
    @(posedge clk);
    #1;
    exp_prot[0] = PC;
    chk("noset_prot", {31'h0, prot_a}, {31'h0, exp_prot[0]});
    chk("noset_pready", {31'h0, pready_a}, 32'h0);
    idle();
    idle();
    chk("noset_sticky", {31'h0, prot_a}, {31'h0, exp_prot[0]});
    do_reset(1);

    // paddr changed mid-ACCESS: target stays at the SETUP address.
    @(negedge clk);
    sel = 1; psel = 1'b1; penable = 1'b0; paddr = 32'h10; pwrite = 1'b1; pwdata = 32'hBEEF_0001;
    @(posedge clk);
    @(negedge clk);
    penable = 1'b1; paddr = 32'h14;
    seen = 0; k = 0;
    while (!seen && k < 20) begin
      if (pready_b) seen = 1;
      else begin k++; @(posedge clk); @(negedge clk); end
    end
    chk("pchg_cycles", k + 2, 2 + WS_B);
    @(posedge clk);
    #1;
    if (seen) mdl[1][4] = 32'hBEEF_0001;
    exp_prot[1] = PC;
    idle();
    chk("pchg_prot", {31'h0, prot_b}, {31'h0, exp_prot[1]});
    rtx(1, 1'b0, 32'h0000_0010, 32'h0);
    rtx(1, 1'b0, 32'h0000_0014, 32'h0);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_slave_regfile.md
Name: apb_slave_regfile

Overview:
APB3 completer (responder) that terminates one select line of the 32-bit APB bus and exposes a bank of word-addressed read/write registers. The bus master drives paddr/pwrite/pwdata/penable and the per-slave psel bit. This block drives prdata, pready and pslverr. It inserts a configurable number of wait states, flags out-of-range or misaligned accesses with pslverr, and exports register 0 as a control word to local logic.

Parameters:
NUM_REGS, 16, number of 32-bit registers; power of two, 2..256
WAIT_STATES, 0, pready-low cycles inserted in each ACCESS phase; 0..15
RESET_VAL, 32'h0, reset value of every register

Ports:
pclk  input  1  bus clock; all logic on rising edge
presetn  input  1  reset, synchronous, active-low
psel  input  1  select bit for this slave (one bit of the bus psel vector)
penable  input  1  APB enable; high marks the ACCESS phase
paddr  input  32  byte address
pwrite  input  1  1 = write, 0 = read
pwdata  input  32  write data
prdata  output  32  read data
pready  output  1  transfer completes on an edge where this is high
pslverr  output  1  error response, valid only while pready is high
ctrl_out  output  32  current contents of register 0
prot_err  output  1  sticky protocol-violation flag (see Optional Feature)

Behaviour:
- Reset: presetn low at a pclk edge sets state=IDLE, wait counter=0 and all registers=RESET_VAL. prdata, pready, pslverr and prot_err are 0 while in reset and on the first cycle after it.
- Reset during a transfer: the transfer is abandoned and no register write occurs.
- Decode: idx = paddr[2+:log2(NUM_REGS)].
- addr_err is set when paddr[1:0] != 0, or when any bit of paddr above idx is non-zero.
- FSM state IDLE:
  - pready=0, pslverr=0, prdata=0.
  - On an edge with psel=1 and penable=0 (SETUP): latch idx, pwrite and addr_err; load cnt=WAIT_STATES; go to ACCESS.
  - psel=0, or penable=1 without a preceding SETUP: stay in IDLE.
- FSM state ACCESS:
  - pready = (cnt==0).
  - If cnt != 0: decrement cnt on each edge.
  - If cnt == 0, the completing edge returns the FSM to IDLE. The next SETUP can be sampled on the following edge, so back-to-back transfers take (2 + WAIT_STATES) cycles each.
- Latency: WAIT_STATES=0 gives zero-wait, 2-cycle transfers.
- Write: on the completing edge, if the latched addr_err=0, reg[idx] <= pwdata (full 32 bits, no byte strobes). If addr_err=1, the write is dropped.
- Read: while pready=1 and the latched pwrite=0, prdata = reg[idx] when addr_err=0, else 32'h0. prdata is 0 at all other times.
- pslverr = pready & latched addr_err.
- ctrl_out follows reg[0] and updates on the edge after its write completes.
- psel drop during ACCESS: the FSM returns to IDLE with no write and no response. prot_err is set if the feature is compiled in.
- Inputs are sampled on the SETUP edge. Changes to paddr or pwrite during ACCESS do not alter the decoded target. pwdata is taken on the completing edge.

Optional Feature:
Macro APB_SLV_PROTOCOL_CHECK_EN.
- Defined: prot_err is set to 1 on the edge after any of these events, and stays set until reset:
  - penable=1 with psel=1 while in IDLE, with no SETUP cycle;
  - paddr or pwrite differing from the SETUP value while in ACCESS;
  - psel falling in ACCESS before pready=1.
- Not defined: the checker logic is absent and prot_err is tied to 0. Data-path behaviour is identical in both builds.

Test Plan:
- Reset: presetn=0 for 2 cycles, then read 0x00 and 0x3C -> prdata=0x0 both times, pslverr=0, ctrl_out=0x0.
- Write/read, WAIT_STATES=0: write 0xDEADBEEF to 0x08, then read 0x08 -> pready high in the first ACCESS cycle, prdata=0xDEADBEEF, each transfer takes 2 cycles.
- Wait states, WAIT_STATES=3: read 0x04 -> pready low for 3 ACCESS cycles and high on the 4th; an overlapping write to 0x04 with 0x1234 is committed only on the pready edge.
- Errors, NUM_REGS=16:
  - write 0xFFFF to 0x40 -> pslverr=1 and no register changes;
  - read 0x06 -> pslverr=1, prdata=0;
  - a following read of 0x00 -> pslverr=0.
- Back-to-back plus ctrl_out: write 0xA5 to 0x00, then immediately read 0x00 -> SETUP accepted on the cycle after completion, ctrl_out=0xA5 one edge after the write, read returns 0xA5.
- Protocol check, APB_SLV_PROTOCOL_CHECK_EN defined:
  - penable=1 with psel=1 and no SETUP -> prot_err=1 and stays set;
  - reset -> prot_err=0;
  - paddr changed mid-ACCESS -> prot_err=1;
  - with the macro undefined, the same stimulus leaves prot_err=0.
